// File: rtl/adder_result_checker.sv
// Cycle-accurate scoreboard comparing a DUV adder against a reference adder.
// Counts vectors and errors, classifies mismatches by field, latches the first failure.
module adder_result_checker #(
    parameter int N           = 8,
    parameter int TYPE        = 1,
    parameter int NUM_VECTORS = 30000,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cin,
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       b,
    input  logic [N-1:0]       s_ref,
    input  logic [N-1:0]       s_duv,
    input  logic               cout_ref,
    input  logic               cout_duv,
    input  logic               prop_ref,
    input  logic               prop_duv,
    input  logic               gen_ref,
    input  logic               gen_duv,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   vec_count,
    output logic [CNT_W-1:0]   err_count,
    output logic               err_pulse,
    output logic [3:0]         err_mask,
    output logic               first_err_valid,
    output logic [2*N:0]       first_err_vec,
    output logic [CNT_W-1:0]   first_err_index
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    // Case-inequality makes any X/Z on a compared pair a mismatch in simulation;
    // prop/gen are only meaningful for lookahead adders.
    function automatic logic [3:0] mismatch_mask(
        input logic [N-1:0] sr,
        input logic [N-1:0] sd,
        input logic         cr,
        input logic         cd,
        input logic         pr,
        input logic         pd,
        input logic         gr,
        input logic         gd
    );
        logic [3:0] m;
        m    = 4'b0000;
        m[0] = (sr !== sd);
        m[1] = (cr !== cd);
        m[2] = (TYPE != 0) ? (pr !== pd) : 1'b0;
        m[3] = (TYPE != 0) ? (gr !== gd) : 1'b0;
        return m;
    endfunction

    state_t           state_r;
    state_t           state_n;
    logic             sample_s;
    logic             clear_s;
    logic             last_s;
    logic             fail_s;
    logic [3:0]       mask_s;
    logic [CNT_W-1:0] err_next_s;

    // Next-state logic for the run controller.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_n = ST_RUN;
                else       state_n = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_n = ST_DONE;
                else        state_n = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_n = ST_RUN;
                else       state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Sampling qualifiers, mismatch classification and saturating error count.
    always_comb begin
        sample_s   = (state_r == ST_RUN);
        clear_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_s     = sample_s && (vec_count == LAST_IDX);
        mask_s     = mismatch_mask(s_ref, s_duv, cout_ref, cout_duv,
                                   prop_ref, prop_duv, gen_ref, gen_duv);
        fail_s     = sample_s && (mask_s != 4'b0000);
        err_next_s = err_count;
        if (fail_s) begin
            if (err_count == CNT_MAX) err_next_s = err_count;
            else                      err_next_s = err_count + CNT_ONE;
        end else begin
            err_next_s = err_count;
        end
    end

    // State register and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_count       <= CNT_ZERO;
            err_count       <= CNT_ZERO;
            err_pulse       <= 1'b0;
            err_mask        <= 4'b0000;
            first_err_valid <= 1'b0;
            first_err_vec   <= {(2*N+1){1'b0}};
            first_err_index <= CNT_ZERO;
        end else begin
            state_r   <= state_n;
            busy      <= (state_n == ST_RUN);
            done      <= (state_n == ST_DONE);
            // pass is evaluated with the final vector's accounting already folded in.
            pass      <= (state_n == ST_DONE) && (err_next_s == CNT_ZERO);
            err_pulse <= fail_s;
            if (clear_s) begin
                vec_count       <= CNT_ZERO;
                err_count       <= CNT_ZERO;
                err_mask        <= 4'b0000;
                first_err_valid <= 1'b0;
                first_err_vec   <= {(2*N+1){1'b0}};
                first_err_index <= CNT_ZERO;
            end else if (sample_s) begin
                vec_count <= vec_count + CNT_ONE;
                err_count <= err_next_s;
                if (fail_s) begin
                    err_mask <= mask_s;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= {cin, a, b};
                        first_err_index <= vec_count;
                    end else begin
                        first_err_valid <= first_err_valid;
                    end
                end else begin
                    err_mask <= err_mask;
                end
            end else begin
                vec_count <= vec_count;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench: runs push expected end-of-run status, a monitor pops on done.
module tb_adder_result_checker;

    typedef struct packed {
        logic        pass;
        logic [15:0] vcnt;
        logic [15:0] ecnt;
        logic [3:0]  mask;
        logic        fev;
        logic [16:0] fvec;
        logic [15:0] fidx;
        logic [15:0] pulses;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;
    logic       cin;
    logic [7:0] a, b, s_ref, s_duv;
    logic       cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv;

    // dut m: TYPE=1, t: TYPE=0, c: CNT_W=4 / 15 vectors
    logic        busy_m, done_m, pass_m, pulse_m, fev_m;
    logic [15:0] vc_m, ec_m, fidx_m;
    logic [3:0]  em_m;
    logic [16:0] fvec_m;
    logic        busy_t, done_t, pass_t, pulse_t, fev_t;
    logic [15:0] vc_t, ec_t, fidx_t;
    logic [3:0]  em_t;
    logic [16:0] fvec_t;
    logic        busy_c, done_c, pass_c, pulse_c, fev_c;
    logic [3:0]  vc_c, ec_c, fidx_c;
    logic [3:0]  em_c;
    logic [16:0] fvec_c;

    logic [2:0] busy_v, done_v, pulse_v;
    assign busy_v  = {busy_c, busy_t, busy_m};
    assign done_v  = {done_c, done_t, done_m};
    assign pulse_v = {pulse_c, pulse_t, pulse_m};

    adder_result_checker #(.N(8), .TYPE(1), .NUM_VECTORS(16), .CNT_W(16)) u_dut_m (
        .clk(clk), .rst(rst), .start(start[0]), .cin(cin), .a(a), .b(b),
        .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
        .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
        .busy(busy_m), .done(done_m), .pass(pass_m), .vec_count(vc_m), .err_count(ec_m),
        .err_pulse(pulse_m), .err_mask(em_m), .first_err_valid(fev_m),
        .first_err_vec(fvec_m), .first_err_index(fidx_m));

    adder_result_checker #(.N(8), .TYPE(0), .NUM_VECTORS(16), .CNT_W(16)) u_dut_t (
        .clk(clk), .rst(rst), .start(start[1]), .cin(cin), .a(a), .b(b),
        .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
        .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
        .busy(busy_t), .done(done_t), .pass(pass_t), .vec_count(vc_t), .err_count(ec_t),
        .err_pulse(pulse_t), .err_mask(em_t), .first_err_valid(fev_t),
        .first_err_vec(fvec_t), .first_err_index(fidx_t));

    adder_result_checker #(.N(8), .TYPE(1), .NUM_VECTORS(15), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .cin(cin), .a(a), .b(b),
        .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
        .prop_ref(prop_ref), .prop_duv(prop_duv), .gen_ref(gen_ref), .gen_duv(gen_duv),
        .busy(busy_c), .done(done_c), .pass(pass_c), .vec_count(vc_c), .err_count(ec_c),
        .err_pulse(pulse_c), .err_mask(em_c), .first_err_valid(fev_c),
        .first_err_vec(fvec_c), .first_err_index(fidx_c));

    int   checks = 0;
    int   errors = 0;
    int   test_id = 0;
    exp_t q_m[$];
    exp_t q_t[$];
    exp_t q_c[$];

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d test%0d got %0h expected %0h", name, k, test_id, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [15:0] vc, input logic [15:0] ec,
                                input logic [3:0] m, input logic fv, input logic [16:0] fvec,
                                input logic [15:0] fi, input logic [15:0] pu);
        exp_t e;
        e.pass = p; e.vcnt = vc; e.ecnt = ec; e.mask = m;
        e.fev = fv; e.fvec = fvec; e.fidx = fi; e.pulses = pu;
        return e;
    endfunction

    function automatic exp_t snap(input int k);
        exp_t s;
        s = '0;
        case (k)
            0: begin
                s.pass = pass_m; s.vcnt = vc_m; s.ecnt = ec_m; s.mask = em_m;
                s.fev = fev_m; s.fvec = fvec_m; s.fidx = fidx_m;
            end
            1: begin
                s.pass = pass_t; s.vcnt = vc_t; s.ecnt = ec_t; s.mask = em_t;
                s.fev = fev_t; s.fvec = fvec_t; s.fidx = fidx_t;
            end
            default: begin
                s.pass = pass_c; s.vcnt = {12'd0, vc_c}; s.ecnt = {12'd0, ec_c}; s.mask = em_c;
                s.fev = fev_c; s.fvec = fvec_c; s.fidx = {12'd0, fidx_c};
            end
        endcase
        return s;
    endfunction

    task automatic cmp_all(input int k, input exp_t act, input exp_t e);
        chk(k, "pass", 32'(act.pass), 32'(e.pass));
        chk(k, "vec_count", 32'(act.vcnt), 32'(e.vcnt));
        chk(k, "err_count", 32'(act.ecnt), 32'(e.ecnt));
        chk(k, "err_mask", 32'(act.mask), 32'(e.mask));
        chk(k, "first_err_valid", 32'(act.fev), 32'(e.fev));
        chk(k, "first_err_vec", 32'(act.fvec), 32'(e.fvec));
        chk(k, "first_err_index", 32'(act.fidx), 32'(e.fidx));
        chk(k, "err_pulses", 32'(act.pulses), 32'(e.pulses));
    endtask

    int   pulses [3] = '{0, 0, 0};
    int   wait_c [3] = '{0, 0, 0};
    logic [2:0] busy_q = 3'b000;
    logic [2:0] done_q = 3'b000;

    task automatic check_run(input int k);
        exp_t act, e;
        bit   have;
        have = 1'b0;
        e = '0;
        if (k == 0 && q_m.size() > 0) begin e = q_m.pop_front(); have = 1'b1; end
        if (k == 1 && q_t.size() > 0) begin e = q_t.pop_front(); have = 1'b1; end
        if (k == 2 && q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        act = snap(k);
        act.pulses = 16'(pulses[k]);
        chk(k, "done_held", 32'(done_v[k]), 32'd1);
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d test%0d got done with no expectation", k, test_id);
        end else begin
            cmp_all(k, act, e);
        end
    endtask

    // Monitor: counts err_pulse per run and compares status a few cycles after done rises.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k] && !busy_q[k]) pulses[k] = 0;
                if (pulse_v[k]) pulses[k]++;
                if (done_v[k] && !done_q[k]) begin
                    wait_c[k] = 3;
                end else if (wait_c[k] > 0) begin
                    wait_c[k]--;
                    if (wait_c[k] == 0) check_run(k);
                end
                busy_q[k] = busy_v[k];
                done_q[k] = done_v[k];
            end
        end
    end

    function automatic logic [16:0] vec_of(input int i);
        logic [7:0] va, vb;
        logic       vc;
        if (i == 5) return {1'b0, 8'hFF, 8'h01};
        va = 8'(i * 37 + 3);
        vb = 8'(i * 91 + 11);
        vc = i[0];
        return {vc, va, vb};
    endfunction

    function automatic logic [3:0] fault_of(input int i);
        case (test_id)
            2:       return (i == 5) ? 4'b0001 : 4'b0000;
            3:       return 4'b0100;
            4:       return (i == 3) ? 4'b1010 : ((i == 9) ? 4'b0001 : 4'b0000);
            6:       return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic drive(input int i, input logic [3:0] f);
        logic [16:0] v;
        logic [8:0]  full, ab;
        v = vec_of(i);
        cin = v[16]; a = v[15:8]; b = v[7:0];
        full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        ab   = {1'b0, a} + {1'b0, b};
        s_ref = full[7:0]; cout_ref = full[8];
        prop_ref = &(a ^ b); gen_ref = ab[8];
        s_duv = s_ref ^ {7'd0, f[0]};
        cout_duv = cout_ref ^ f[1];
        prop_duv = prop_ref ^ f[2];
        gen_duv  = gen_ref ^ f[3];
    endtask

    task automatic run(input logic [2:0] sel, input int nvec, input int hold, input int abort_at);
        int n;
        bit aborted;
        aborted = 1'b0;
        @(negedge clk);
        start = sel;
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            if (i >= hold) start = 3'b000;
            drive(i, fault_of(i));
            if (i == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            n = 0;
            @(negedge clk);
            while (((done_v & sel) != sel) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk(0, "done_reached", 32'((done_v & sel) == sel), 32'd1);
            drive(0, 4'b0000);
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic chk_reset(input int k);
        exp_t s;
        s = snap(k);
        chk(k, "rst_busy", 32'(busy_v[k]), 32'd0);
        chk(k, "rst_done", 32'(done_v[k]), 32'd0);
        chk(k, "rst_err_pulse", 32'(pulse_v[k]), 32'd0);
        s.pulses = 16'd0;
        cmp_all(k, s, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 3'b000;
        drive(0, 4'b0000);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset(k);
        rst = 1'b0;

        test_id = 1;
        q_m.push_back(mk(1'b1, 16'd16, 16'd0, 4'b0000, 1'b0, 17'h00000, 16'd0, 16'd0));
        run(3'b001, 16, 0, -1);

        test_id = 2;
        q_m.push_back(mk(1'b0, 16'd16, 16'd1, 4'b0001, 1'b1, 17'h0FF01, 16'd5, 16'd1));
        run(3'b001, 16, 0, -1);

        test_id = 3;
        q_m.push_back(mk(1'b0, 16'd16, 16'd16, 4'b0100, 1'b1, 17'h0030B, 16'd0, 16'd16));
        q_t.push_back(mk(1'b1, 16'd16, 16'd0, 4'b0000, 1'b0, 17'h00000, 16'd0, 16'd0));
        run(3'b011, 16, 0, -1);

        test_id = 4;
        q_m.push_back(mk(1'b0, 16'd16, 16'd2, 4'b0001, 1'b1, 17'h1721C, 16'd3, 16'd2));
        run(3'b001, 16, 0, -1);

        test_id = 5;
        run(3'b001, 16, 0, 7);
        @(negedge clk);
        chk_reset(0);
        rst = 1'b0;
        q_m.push_back(mk(1'b1, 16'd16, 16'd0, 4'b0000, 1'b0, 17'h00000, 16'd0, 16'd0));
        run(3'b001, 16, 0, -1);

        test_id = 6;
        q_c.push_back(mk(1'b0, 16'd15, 16'd15, 4'b0001, 1'b1, 17'h0030B, 16'd0, 16'd15));
        run(3'b100, 15, 5, -1);

        repeat (4) @(negedge clk);
        chk(0, "pending_m", 32'(q_m.size()), 32'd0);
        chk(1, "pending_t", 32'(q_t.size()), 32'd0);
        chk(2, "pending_c", 32'(q_c.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Synthesizable scoreboard placed directly downstream of the DUV adder and the reference adder in the adder verification benches.
- Each clock it samples one applied vector (cin, a, b) together with both result sets, and classifies any mismatch by field.
- It counts vectors and errors, latches the first failing vector, and raises done/pass after NUM_VECTORS vectors.
- It replaces the free-running behavioural comparator with deterministic, cycle-accurate status that can be read back.

Parameters:
- N, 8, operand/sum width.
- TYPE, 1, 0 = ripple/select adders (check s and cout only); 1 = lookahead adders (also check prop and gen).
- NUM_VECTORS, 30000, number of vectors checked per run.
- CNT_W, 16, width of the vector and error counters; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- clk  in  1  bench clock; all sampling on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- cin  in  1  applied carry-in.
- a  in  N  applied operand A.
- b  in  N  applied operand B.
- s_ref  in  N  reference sum.
- s_duv  in  N  DUV sum.
- cout_ref  in  1  reference carry-out.
- cout_duv  in  1  DUV carry-out.
- prop_ref  in  1  reference group propagate.
- prop_duv  in  1  DUV group propagate.
- gen_ref  in  1  reference group generate.
- gen_duv  in  1  DUV group generate.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; high when err_count == 0.
- vec_count  out  CNT_W  number of vectors checked so far.
- err_count  out  CNT_W  number of failing vectors; saturates at all-ones.
- err_pulse  out  1  one-cycle pulse, registered, one cycle after a failing sample.
- err_mask  out  4  mismatch fields of the most recent failing vector: [0] sum, [1] cout, [2] prop, [3] gen.
- first_err_valid  out  1  high once a first error has been captured.
- first_err_vec  out  2N+1  {cin, a, b} of the first failing vector.
- first_err_index  out  CNT_W  vec_count value at the first failure.

Behaviour:
- Reset (rst high at a clock edge): go to IDLE.
  - Outputs after reset: busy=0, done=0, pass=0, vec_count=0, err_count=0, err_pulse=0, err_mask=0, first_err_valid=0, first_err_vec=0, first_err_index=0.
  - Reset wins over every other input at the same edge, including mid-run.
- States:
  - IDLE: when start=1, go to RUN and clear all counters and first_err_* fields. Otherwise stay.
  - RUN: each edge samples one vector and increments vec_count.
    - When the sample brings vec_count to NUM_VECTORS, go to DONE at that same edge.
    - start is ignored in RUN.
  - DONE: done=1; pass = (err_count == 0), held stable.
    - start=1 clears everything and goes to RUN; the first vector is sampled at the following edge.
- Mismatch mask (combinational on sampled inputs):
  - bit0 = (s_ref != s_duv).
  - bit1 = (cout_ref != cout_duv).
  - bit2 = TYPE ? (prop_ref != prop_duv) : 0.
  - bit3 = TYPE ? (gen_ref != gen_duv) : 0.
  - A vector fails when the mask is nonzero.
- On a failing sample in RUN:
  - err_count increments, stopping at 2^CNT_W-1.
  - err_mask is loaded with the mask.
  - err_pulse is high during the next cycle only.
  - If first_err_valid=0: load first_err_vec, load first_err_index with the pre-increment vec_count, and set first_err_valid.
- On the final vector, error accounting completes at the same edge as the move to DONE, so pass already reflects that vector.
- Comparison is X-strict: any X/Z on a compared pair counts as a mismatch (case-inequality in simulation).
- No sampling occurs in IDLE or DONE; input changes there have no effect.
- Latency:
  - Counters update at the sampling edge.
  - err_pulse lags the sampling edge by one cycle.
  - done rises at the edge that samples the last vector.

Test Plan:
- Matched models, N=8, NUM_VECTORS=16, start pulse → busy for 16 cycles, then done=1, pass=1, vec_count=16, err_count=0, first_err_valid=0.
- Force s_duv = s_ref^8'h01 on vector index 5 only (a=8'hFF, b=8'h01, cin=0) → err_count=1, err_mask=4'b0001, first_err_index=5, first_err_vec={1'b0,8'hFF,8'h01}, pass=0, one err_pulse.
- TYPE=0 with prop_duv permanently inverted → err_count=0, pass=1. TYPE=1 with the same fault → err_count=16, err_mask=4'b0100.
- cout and gen wrong on vector 3, sum wrong on vector 9 → first_err_index=3, err_mask=4'b0001 at the end, err_count=2.
- rst asserted at vector 7 of a run → next cycle all outputs zero and IDLE; a later start runs 16 vectors cleanly.
- CNT_W=4, NUM_VECTORS=15, every vector failing → err_count saturates at 15 without wrapping, done=1, pass=0. A start held during RUN causes no restart.
